ospi_req_arbiter: RTL and testbench

//  Shares a single ospi_controller request/response port between NUM_REQ

---
 rtl/ospi_req_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_ospi_req_arbiter.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ospi_req_arbiter.sv
// Round-robin arbiter sharing one ospi_controller request/response port among
// NUM_REQ requesters; load responses are routed back in order through a tag FIFO.
module ospi_req_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_REQ-1:0]                     m_req_valid,
  input  logic [NUM_REQ-1:0]                     m_req_is_load,
  input  logic [NUM_REQ*32-1:0]                  m_req_addr,
  input  logic [NUM_REQ*32-1:0]                  m_req_wdata,
  input  logic [NUM_REQ*5-1:0]                   m_req_rd,
  output logic [NUM_REQ-1:0]                     m_req_ready,
  output logic [NUM_REQ-1:0]                     m_resp_valid,
  output logic [4:0]                             m_resp_rd,
  output logic [31:0]                            m_resp_data,
  output logic                                   s_req_valid,
  output logic                                   s_req_is_load,
  output logic [31:0]                            s_req_addr,
  output logic [31:0]                            s_req_wdata,
  output logic [4:0]                             s_req_rd,
  input  logic                                   s_req_ready,
  input  logic                                   s_resp_valid,
  input  logic [4:0]                             s_resp_rd,
  input  logic [31:0]                            s_resp_data,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
  output logic                                   resp_err
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   grant_id;
  logic              grant_any;
  logic [NUM_REQ-1:0] eligible;

  logic              held_is_load;
  logic [31:0]       held_addr;
  logic [31:0]       held_wdata;
  logic [4:0]        held_rd;
  logic [ID_W-1:0]   held_id;

  logic              pending_load;
  logic [CNT_W:0]    load_budget;

  logic [ID_W-1:0]   tag_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push;
  logic              pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // A captured-but-unissued load already owns a FIFO slot.
  assign pending_load = (state == ISSUE) && held_is_load;
  assign load_budget  = {1'b0, outstanding} + (CNT_W+1)'(pending_load);

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = m_req_valid[i] &&
                    (!m_req_is_load[i] || (load_budget < (CNT_W+1)'(MAX_OUTSTANDING)));
    end
  end

  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_any && eligible[ID_W'((int'(rr_ptr) + k) % NUM_REQ)]) begin
        grant_any = 1'b1;
        grant_id  = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    m_req_ready = '0;
    if (!rst && (state == IDLE) && grant_any) begin
      m_req_ready[grant_id] = 1'b1;
    end
  end

  assign s_req_is_load = held_is_load;
  assign s_req_addr    = held_addr;
  assign s_req_wdata   = held_wdata;
  assign s_req_rd      = held_rd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      s_req_valid  <= 1'b0;
      held_is_load <= 1'b0;
      held_addr    <= '0;
      held_wdata   <= '0;
      held_rd      <= '0;
      held_id      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            held_is_load <= m_req_is_load[grant_id];
            held_addr    <= m_req_addr[grant_id*32 +: 32];
            held_wdata   <= m_req_wdata[grant_id*32 +: 32];
            held_rd      <= m_req_rd[grant_id*5 +: 5];
            held_id      <= grant_id;
            rr_ptr       <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
            s_req_valid  <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          if (s_req_ready) begin
            s_req_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          s_req_valid <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  // A response with nothing outstanding is dropped and flagged, never popped.
  assign push = s_req_valid && s_req_ready && held_is_load;
  assign pop  = s_resp_valid && (outstanding != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem[wr_ptr] <= held_id;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      outstanding  <= '0;
      resp_err     <= 1'b0;
      m_resp_valid <= '0;
      m_resp_rd    <= '0;
      m_resp_data  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase

      m_resp_valid <= '0;
      if (pop) begin
        m_resp_valid[tag_mem[rd_ptr]] <= 1'b1;
        m_resp_rd                     <= s_resp_rd;
        m_resp_data                   <= s_resp_data;
      end

      if (s_resp_valid && (outstanding == '0)) begin
        resp_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ospi_req_arbiter.sv
// Self-checking bench: transaction-level model (queues) compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ospi_req_arbiter;

  localparam int NUM_REQ = 4;
  localparam int MAX_OUT = 4;
  localparam int CNT_W   = $clog2(MAX_OUT + 1);

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_REQ-1:0]    m_req_valid;
  logic [NUM_REQ-1:0]    m_req_is_load;
  logic [NUM_REQ*32-1:0] m_req_addr;
  logic [NUM_REQ*32-1:0] m_req_wdata;
  logic [NUM_REQ*5-1:0]  m_req_rd;
  logic [NUM_REQ-1:0]    m_req_ready;
  logic [NUM_REQ-1:0]    m_resp_valid;
  logic [4:0]            m_resp_rd;
  logic [31:0]           m_resp_data;
  logic                  s_req_valid;
  logic                  s_req_is_load;
  logic [31:0]           s_req_addr;
  logic [31:0]           s_req_wdata;
  logic [4:0]            s_req_rd;
  logic                  s_req_ready;
  logic                  s_resp_valid;
  logic [4:0]            s_resp_rd;
  logic [31:0]           s_resp_data;
  logic [CNT_W-1:0]      outstanding;
  logic                  resp_err;

  ospi_req_arbiter #(.NUM_REQ(NUM_REQ), .MAX_OUTSTANDING(MAX_OUT)) dut (
    .clk(clk), .rst(rst),
    .m_req_valid(m_req_valid), .m_req_is_load(m_req_is_load),
    .m_req_addr(m_req_addr), .m_req_wdata(m_req_wdata), .m_req_rd(m_req_rd),
    .m_req_ready(m_req_ready), .m_resp_valid(m_resp_valid),
    .m_resp_rd(m_resp_rd), .m_resp_data(m_resp_data),
    .s_req_valid(s_req_valid), .s_req_is_load(s_req_is_load),
    .s_req_addr(s_req_addr), .s_req_wdata(s_req_wdata), .s_req_rd(s_req_rd),
    .s_req_ready(s_req_ready), .s_resp_valid(s_resp_valid),
    .s_resp_rd(s_resp_rd), .s_resp_data(s_resp_data),
    .outstanding(outstanding), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: one captured request waiting for the controller, a queue of
  // requester ids for loads in flight, and the response that will strobe next.
  typedef struct {
    bit          is_load;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    int          id;
  } req_t;

  req_t        cur;
  bit          have_req;
  int          tags[$];
  int          rr;
  bit          err;
  bit          resp_strobe;
  int          resp_id;
  logic [4:0]  bus_rd;
  logic [31:0] bus_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    have_req    = 1'b0;
    tags.delete();
    rr          = 0;
    err         = 1'b0;
    resp_strobe = 1'b0;
    resp_id     = 0;
    bus_rd      = '0;
    bus_data    = '0;
    cur         = '{1'b0, 32'h0, 32'h0, 5'h0, 0};
  endtask

  function automatic int modelGrant();
    int id;
    if (rst || have_req) return -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      id = (rr + k) % NUM_REQ;
      if (m_req_valid[id] && (!m_req_is_load[id] || tags.size() < MAX_OUT)) return id;
    end
    return -1;
  endfunction

  task automatic clearInputs();
    m_req_valid   = '0;
    m_req_is_load = '0;
    m_req_addr    = '0;
    m_req_wdata   = '0;
    m_req_rd      = '0;
    s_req_ready   = 1'b0;
    s_resp_valid  = 1'b0;
    s_resp_rd     = '0;
    s_resp_data   = '0;
  endtask

  task automatic applyStimulus();
    #2;
    if (rst) modelReset();
  endtask

  task automatic checkOutput();
    int               g;
    logic [NUM_REQ-1:0] exp_ready;
    logic [NUM_REQ-1:0] exp_resp;
    g         = modelGrant();
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    exp_resp = '0;
    if (resp_strobe) exp_resp[resp_id] = 1'b1;
    check("m_req_ready", m_req_ready, exp_ready);
    check("s_req_valid", s_req_valid, have_req);
    if (have_req) begin
      check("s_req_is_load", s_req_is_load, cur.is_load);
      check("s_req_addr", s_req_addr, cur.addr);
      check("s_req_wdata", s_req_wdata, cur.wdata);
      check("s_req_rd", s_req_rd, cur.rd);
    end
    check("m_resp_valid", m_resp_valid, exp_resp);
    check("m_resp_rd", m_resp_rd, bus_rd);
    check("m_resp_data", m_resp_data, bus_data);
    check("outstanding", outstanding, tags.size());
    check("resp_err", resp_err, err);
  endtask

  task automatic advance();
    int g;
    if (!rst) begin
      g           = modelGrant();
      resp_strobe = 1'b0;
      if (s_resp_valid) begin
        if (tags.size() > 0) begin
          resp_id     = tags.pop_front();
          resp_strobe = 1'b1;
          bus_rd      = s_resp_rd;
          bus_data    = s_resp_data;
        end else begin
          err = 1'b1;
        end
      end
      if (g >= 0) begin
        cur.is_load = m_req_is_load[g];
        cur.addr    = m_req_addr[g*32 +: 32];
        cur.wdata   = m_req_wdata[g*32 +: 32];
        cur.rd      = m_req_rd[g*5 +: 5];
        cur.id      = g;
        have_req    = 1'b1;
        rr          = (g + 1) % NUM_REQ;
      end else if (have_req && s_req_ready) begin
        if (cur.is_load) tags.push_back(cur.id);
        have_req = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic cycle();
    checkOutput();
    advance();
  endtask

  task automatic doReset();
    clearInputs();
    rst = 1'b1;
    applyStimulus();
    cycle();
    rst = 1'b0;
  endtask

  function automatic int onehotIndex(input logic [NUM_REQ-1:0] v);
    for (int i = 0; i < NUM_REQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic randomInputs();
    m_req_valid   = NUM_REQ'($urandom);
    m_req_is_load = NUM_REQ'($urandom);
    for (int i = 0; i < NUM_REQ; i++) begin
      m_req_addr[i*32 +: 32]  = $urandom;
      m_req_wdata[i*32 +: 32] = $urandom;
      m_req_rd[i*5 +: 5]      = 5'($urandom);
    end
    s_req_ready  = ($urandom_range(0, 3) != 0);
    s_resp_valid = ((tags.size() > 0) && ($urandom_range(0, 2) == 0)) ||
                   ($urandom_range(0, 199) == 0);
    s_resp_rd    = 5'($urandom);
    s_resp_data  = $urandom;
    rst          = ($urandom_range(0, 399) == 0);
  endtask

  int gq[$];
  int gc[$];
  int exp_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    modelReset();
    clearInputs();
    rst = 1'b1;
    applyStimulus();
    check("rst_s_req_valid", s_req_valid, 1'b0);
    check("rst_s_req_addr", s_req_addr, 32'h0);
    check("rst_outstanding", outstanding, 0);
    check("rst_resp_err", resp_err, 1'b0);
    check("rst_m_resp_valid", m_resp_valid, 4'b0000);
    cycle();
    rst = 1'b0;

    // Scenario 1: single store from requester 0
    clearInputs();
    m_req_valid[0]      = 1'b1;
    m_req_wdata[31:0]   = 32'hA5A5_0001;
    s_req_ready         = 1'b1;
    applyStimulus();
    check("t1_ready_pulse", m_req_ready, 4'b0001);
    cycle();
    m_req_valid = '0;
    applyStimulus();
    check("t1_ready_single", m_req_ready, 4'b0000);
    check("t1_s_req_valid", s_req_valid, 1'b1);
    check("t1_s_req_wdata", s_req_wdata, 32'hA5A5_0001);
    check("t1_s_req_is_load", s_req_is_load, 1'b0);
    cycle();
    applyStimulus();
    check("t1_done", s_req_valid, 1'b0);
    check("t1_outstanding", outstanding, 0);
    check("t1_no_resp", m_resp_valid, 4'b0000);
    cycle();

    // Scenario 2: four stores held high rotate fairly
    doReset();
    for (int c = 0; c < 10; c++) begin
      clearInputs();
      m_req_valid = 4'b1111;
      s_req_ready = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) m_req_wdata[i*32 +: 32] = 32'h2000 + i;
      applyStimulus();
      if (m_req_ready != '0) begin
        gq.push_back(onehotIndex(m_req_ready));
        gc.push_back(c);
      end
      cycle();
    end
    check("t2_grant_count", gq.size(), 5);
    for (int i = 0; i < gq.size() && i < 5; i++) check("t2_grant_order", gq[i], exp_order[i]);
    if (gc.size() == 5) check("t2_req0_period", gc[4] - gc[0], 8);

    // Scenario 3: one load on requester 1 and its response
    doReset();
    clearInputs();
    m_req_valid[1]      = 1'b1;
    m_req_is_load[1]    = 1'b1;
    m_req_addr[63:32]   = 32'h4;
    m_req_rd[9:5]       = 5'd2;
    s_req_ready         = 1'b1;
    applyStimulus();
    check("t3_ready", m_req_ready, 4'b0010);
    cycle();
    m_req_valid = '0;
    applyStimulus();
    check("t3_s_req_is_load", s_req_is_load, 1'b1);
    check("t3_s_req_addr", s_req_addr, 32'h4);
    check("t3_s_req_rd", s_req_rd, 5'd2);
    cycle();
    s_resp_valid = 1'b1;
    s_resp_rd    = 5'd2;
    s_resp_data  = 32'h5A5A_0002;
    applyStimulus();
    check("t3_outstanding_1", outstanding, 1);
    cycle();
    s_resp_valid = 1'b0;
    applyStimulus();
    check("t3_resp_valid", m_resp_valid, 4'b0010);
    check("t3_resp_rd", m_resp_rd, 5'd2);
    check("t3_resp_data", m_resp_data, 32'h5A5A_0002);
    check("t3_outstanding_0", outstanding, 0);
    cycle();
    applyStimulus();
    check("t3_strobe_drop", m_resp_valid, 4'b0000);
    check("t3_bus_hold", m_resp_data, 32'h5A5A_0002);
    cycle();

    // Scenario 4: loads fill the FIFO; a store still gets through
    doReset();
    for (int c = 0; c < 12; c++) begin
      clearInputs();
      s_req_ready      = 1'b1;
      m_req_valid[0]   = 1'b1;
      m_req_is_load[0] = 1'b1;
      m_req_rd[4:0]    = 5'(c);
      if (c == 8) begin
        m_req_valid[3]    = 1'b1;
        m_req_addr[127:96] = 32'h30;
      end
      if (c == 10) begin
        s_resp_valid = 1'b1;
        s_resp_rd    = 5'd7;
        s_resp_data  = 32'hC0DE_0004;
      end
      applyStimulus();
      if (c == 6) check("t4_fourth_grant", m_req_ready, 4'b0001);
      if (c == 8) begin
        check("t4_outstanding_full", outstanding, 4);
        check("t4_store_granted", m_req_ready, 4'b1000);
      end
      if (c == 10) begin
        check("t4_load_blocked", m_req_ready, 4'b0000);
        check("t4_outstanding_hold", outstanding, 4);
      end
      if (c == 11) begin
        check("t4_resp_strobe", m_resp_valid, 4'b0001);
        check("t4_outstanding_3", outstanding, 3);
        check("t4_fifth_granted", m_req_ready, 4'b0001);
      end
      cycle();
    end

    // Scenario 5: responses return in issue order (req2 then req0)
    doReset();
    for (int c = 0; c < 7; c++) begin
      clearInputs();
      s_req_ready = 1'b1;
      if (c == 0) begin m_req_valid[2] = 1'b1; m_req_is_load[2] = 1'b1; end
      if (c == 1 || c == 2) begin m_req_valid[0] = 1'b1; m_req_is_load[0] = 1'b1; end
      if (c == 4) begin s_resp_valid = 1'b1; s_resp_rd = 5'd3; s_resp_data = 32'h1111_2222; end
      if (c == 5) begin s_resp_valid = 1'b1; s_resp_rd = 5'd9; s_resp_data = 32'h3333_4444; end
      applyStimulus();
      if (c == 0) check("t5_grant_req2", m_req_ready, 4'b0100);
      if (c == 2) check("t5_grant_req0", m_req_ready, 4'b0001);
      if (c == 5) begin
        check("t5_first_resp", m_resp_valid, 4'b0100);
        check("t5_first_data", m_resp_data, 32'h1111_2222);
      end
      if (c == 6) begin
        check("t5_second_resp", m_resp_valid, 4'b0001);
        check("t5_second_data", m_resp_data, 32'h3333_4444);
        check("t5_second_rd", m_resp_rd, 5'd9);
      end
      cycle();
    end

    // Scenario 6: spurious response, then reset while a request is stalled
    doReset();
    for (int c = 0; c < 6; c++) begin
      clearInputs();
      if (c == 0) s_resp_valid = 1'b1;
      if (c == 1 || c == 3) begin m_req_valid[1] = 1'b1; m_req_is_load[1] = 1'b1; end
      s_req_ready = (c == 2);
      if (c == 5) rst = 1'b1;
      applyStimulus();
      if (c == 1) begin
        check("t6_resp_err_set", resp_err, 1'b1);
        check("t6_no_strobe", m_resp_valid, 4'b0000);
      end
      if (c == 4) begin
        check("t6_stalled_valid", s_req_valid, 1'b1);
        check("t6_outstanding_1", outstanding, 1);
        check("t6_err_sticky", resp_err, 1'b1);
      end
      if (c == 5) begin
        check("t6_rst_s_req_valid", s_req_valid, 1'b0);
        check("t6_rst_outstanding", outstanding, 0);
        check("t6_rst_resp_err", resp_err, 1'b0);
      end
      cycle();
    end
    rst = 1'b0;

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      randomInputs();
      applyStimulus();
      cycle();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
